trade_report_tx: RTL and testbench

- Outbound end of the trade path.
- Captures each trade pulse from order_matching_engine (trade_valid plus price/qty/buy_id/sell_id), buffers it in a small FIFO and serialises it as a fixed 6-byte frame on a byte-wide valid/ready stream.
- The byte stream feeds the host-side link (UART/MAC byte interface).
- Trades arriving while the FIFO is full are dropped and counted; the engine is never stalled.

---
 rtl/trade_pkg.sv | 40 ++++
 rtl/trade_fifo.sv | 57 +++++
 rtl/trade_report_tx.sv | 154 +++++++++++++++
 tb/tb_trade_report_tx.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/trade_pkg.sv
// Shared definitions for the trade report path: frame constants, serialiser
// state encoding and the layout of the 32-bit trade record.
package trade_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         FRAME_LEN         = 6;
    localparam int         REC_WIDTH         = 32;
    localparam int         FIELD_W           = 8;

    // Record layout {price, qty, buy_id, sell_id}, MSB first.
    localparam int PRICE_LSB = 24;
    localparam int QTY_LSB   = 16;
    localparam int BUY_LSB   = 8;
    localparam int SELL_LSB  = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_PRICE = 3'd2,
        ST_QTY   = 3'd3,
        ST_BUY   = 3'd4,
        ST_SELL  = 3'd5,
        ST_CSUM  = 3'd6
    } tx_state_e;

    function automatic logic [REC_WIDTH-1:0] pack_record(
        input logic [7:0] price,
        input logic [7:0] qty,
        input logic [7:0] buy,
        input logic [7:0] sell
    );
        return {price, qty, buy, sell};
    endfunction

    function automatic logic [7:0] frame_csum(input logic [REC_WIDTH-1:0] rec);
        return rec[PRICE_LSB +: FIELD_W] ^ rec[QTY_LSB +: FIELD_W] ^
               rec[BUY_LSB +: FIELD_W] ^ rec[SELL_LSB +: FIELD_W];
    endfunction

endpackage

// File: rtl/trade_fifo.sv
// Synchronous FIFO with registered occupancy; a push while full is only
// accepted when a pop frees a slot in the same cycle. No fall-through.
module trade_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    // Storage needs no reset; occupancy alone decides what is readable.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/trade_report_tx.sv
// Buffers trade pulses and serialises each as a 6-byte frame
// (sync, price, qty, buy, sell, xor checksum) on a valid/ready byte stream.
module trade_report_tx
    import trade_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
    input  logic                          CLK,
    input  logic                          RESET_N,
    input  logic                          trade_valid,
    input  logic [7:0]                    trade_price,
    input  logic [7:0]                    trade_qty,
    input  logic [7:0]                    buy_id,
    input  logic [7:0]                    sell_id,
    output logic [7:0]                    tx_byte,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic                          tx_last,
    output logic [7:0]                    drop_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    tx_state_e            state_q;
    logic [REC_WIDTH-1:0] shadow_q;
    logic [7:0]           tx_byte_q;
    logic                 tx_valid_q;
    logic                 tx_last_q;
    logic [7:0]           drop_q;
    logic [7:0]           drop_d;

    logic [REC_WIDTH-1:0] fifo_rdata;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 accept;
    logic                 pop;
    logic                 drop;

    assign accept = tx_valid_q && tx_ready;
    assign pop    = !fifo_empty &&
                    ((state_q == ST_IDLE) || (state_q == ST_CSUM && accept));
    assign drop   = trade_valid && fifo_full && !pop;

    trade_fifo #(
        .WIDTH (REC_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (RESET_N),
        .push_i  (trade_valid),
        .wdata_i (pack_record(trade_price, trade_qty, buy_id, sell_id)),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    // Each branch loads the byte for the state being entered, so the stream
    // outputs are registered and simply hold while the sink stalls.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            shadow_q   <= '0;
            tx_byte_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        shadow_q   <= fifo_rdata;
                        state_q    <= ST_HDR;
                        tx_byte_q  <= SYNC_BYTE;
                        tx_valid_q <= 1'b1;
                        tx_last_q  <= 1'b0;
                    end
                end
                ST_HDR: begin
                    if (accept) begin
                        state_q   <= ST_PRICE;
                        tx_byte_q <= shadow_q[PRICE_LSB +: FIELD_W];
                    end
                end
                ST_PRICE: begin
                    if (accept) begin
                        state_q   <= ST_QTY;
                        tx_byte_q <= shadow_q[QTY_LSB +: FIELD_W];
                    end
                end
                ST_QTY: begin
                    if (accept) begin
                        state_q   <= ST_BUY;
                        tx_byte_q <= shadow_q[BUY_LSB +: FIELD_W];
                    end
                end
                ST_BUY: begin
                    if (accept) begin
                        state_q   <= ST_SELL;
                        tx_byte_q <= shadow_q[SELL_LSB +: FIELD_W];
                    end
                end
                ST_SELL: begin
                    if (accept) begin
                        state_q   <= ST_CSUM;
                        tx_byte_q <= frame_csum(shadow_q);
                        tx_last_q <= 1'b1;
                    end
                end
                ST_CSUM: begin
                    if (accept) begin
                        tx_last_q <= 1'b0;
                        if (pop) begin
                            shadow_q  <= fifo_rdata;
                            state_q   <= ST_HDR;
                            tx_byte_q <= SYNC_BYTE;
                        end else begin
                            state_q    <= ST_IDLE;
                            tx_byte_q  <= '0;
                            tx_valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    tx_byte_q  <= '0;
                    tx_valid_q <= 1'b0;
                    tx_last_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        drop_d = drop_q;
        if (drop && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign tx_byte    = tx_byte_q;
    assign tx_valid   = tx_valid_q;
    assign tx_last    = tx_last_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_trade_report_tx.sv
// Directed bench for trade_report_tx: single frame, backpressure, back-to-back,
// overflow, drop saturation and asynchronous reset mid-frame.
module tb_trade_report_tx;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic       trade_valid;
    logic [7:0] trade_price;
    logic [7:0] trade_qty;
    logic [7:0] buy_id;
    logic [7:0] sell_id;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_last;
    logic [7:0] drop_count;
    logic [2:0] fifo_level;

    int         testsRun    = 0;
    int         testsFailed = 0;
    logic [7:0] gotByte [64];
    logic       gotLast [64];
    int         gotN;
    int         gapCount;

    trade_report_tx #(
        .FIFO_DEPTH (4),
        .SYNC_BYTE  (8'hA5)
    ) dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .trade_valid (trade_valid),
        .trade_price (trade_price),
        .trade_qty   (trade_qty),
        .buy_id      (buy_id),
        .sell_id     (sell_id),
        .tx_byte     (tx_byte),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_last     (tx_last),
        .drop_count  (drop_count),
        .fifo_level  (fifo_level)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one trade pulse from a falling edge; returns on the next falling edge.
    task automatic applyStimulus(input logic [7:0] p, input logic [7:0] q,
                                 input logic [7:0] b, input logic [7:0] s);
        trade_price = p;
        trade_qty   = q;
        buy_id      = b;
        sell_id     = s;
        trade_valid = 1'b1;
        @(negedge CLK);
        trade_valid = 1'b0;
    endtask

    // Collects accepted bytes; stallPattern gives tx_ready 1,0,0,1,0,0...
    task automatic captureBytes(input int n, input bit stallPattern, input int budget);
        bit         stalled = 1'b0;
        bit         readyNow;
        logic [7:0] heldByte = '0;
        logic       heldLast = 1'b0;
        gotN     = 0;
        gapCount = 0;
        for (int cyc = 0; cyc < budget && gotN < n; cyc++) begin
            readyNow = stallPattern ? (cyc % 3 == 0) : 1'b1;
            tx_ready = readyNow;
            if (stalled) begin
                checkOutput("holdValid", 32'(tx_valid), 32'd1);
                checkOutput("holdByte", 32'(tx_byte), 32'(heldByte));
                checkOutput("holdLast", 32'(tx_last), 32'(heldLast));
            end
            if (tx_valid && readyNow) begin
                gotByte[gotN] = tx_byte;
                gotLast[gotN] = tx_last;
                gotN++;
                stalled = 1'b0;
            end else if (tx_valid) begin
                stalled  = 1'b1;
                heldByte = tx_byte;
                heldLast = tx_last;
            end else begin
                stalled = 1'b0;
                if (gotN > 0) gapCount++;
            end
            @(negedge CLK);
        end
        checkOutput("byteCount", 32'(gotN), 32'(n));
    endtask

    task automatic checkFrame(input string tag, input int base,
                              input logic [7:0] p, input logic [7:0] q,
                              input logic [7:0] b, input logic [7:0] s,
                              input logic [7:0] c);
        logic [7:0] expByte [6];
        expByte = '{8'hA5, p, q, b, s, c};
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("%s_byte%0d", tag, i), 32'(gotByte[base+i]), 32'(expByte[i]));
            checkOutput($sformatf("%s_last%0d", tag, i), 32'(gotLast[base+i]), (i == 5) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit found;
        int validSeen;

        RESET_N     = 1'b0;
        trade_valid = 1'b0;
        trade_price = '0;
        trade_qty   = '0;
        buy_id      = '0;
        sell_id     = '0;
        tx_ready    = 1'b0;
        @(negedge CLK);
        checkOutput("rstValid", 32'(tx_valid), 32'd0);
        checkOutput("rstByte", 32'(tx_byte), 32'd0);
        checkOutput("rstLast", 32'(tx_last), 32'd0);
        checkOutput("rstDrop", 32'(drop_count), 32'd0);
        checkOutput("rstLevel", 32'(fifo_level), 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);

        // Single trade, sink always ready; SYNC appears two cycles after the pulse.
        tx_ready = 1'b1;
        applyStimulus(8'd42, 8'd10, 8'h07, 8'h03);
        checkOutput("latency1Valid", 32'(tx_valid), 32'd0);
        @(negedge CLK);
        checkOutput("latency2Valid", 32'(tx_valid), 32'd1);
        checkOutput("latency2Sync", 32'(tx_byte), 32'hA5);
        captureBytes(6, 1'b0, 20);
        checkOutput("singleGaps", 32'(gapCount), 32'd0);
        checkFrame("single", 0, 8'h2A, 8'h0A, 8'h07, 8'h03, 8'h24);
        repeat (3) @(negedge CLK);
        checkOutput("singleIdle", 32'(tx_valid), 32'd0);
        checkOutput("singleLevel", 32'(fifo_level), 32'd0);

        // Same trade under backpressure.
        tx_ready = 1'b0;
        applyStimulus(8'd42, 8'd10, 8'h07, 8'h03);
        captureBytes(6, 1'b1, 60);
        checkFrame("stall", 0, 8'h2A, 8'h0A, 8'h07, 8'h03, 8'h24);
        repeat (3) @(negedge CLK);
        checkOutput("stallIdle", 32'(tx_valid), 32'd0);

        // Back-to-back trades must give 12 contiguous bytes.
        tx_ready = 1'b1;
        applyStimulus(8'h05, 8'h01, 8'h10, 8'h20);
        applyStimulus(8'h06, 8'h02, 8'h11, 8'h21);
        captureBytes(12, 1'b0, 40);
        checkOutput("b2bGaps", 32'(gapCount), 32'd0);
        checkFrame("b2bA", 0, 8'h05, 8'h01, 8'h10, 8'h20, 8'h34);
        checkFrame("b2bB", 6, 8'h06, 8'h02, 8'h11, 8'h21, 8'h34);
        repeat (3) @(negedge CLK);
        checkOutput("b2bIdle", 32'(tx_valid), 32'd0);

        // Overflow: six trades with the sink stalled; the sixth is dropped.
        tx_ready = 1'b0;
        applyStimulus(8'h10, 8'h01, 8'h02, 8'h03);
        applyStimulus(8'h20, 8'h04, 8'h05, 8'h06);
        applyStimulus(8'h30, 8'h07, 8'h08, 8'h09);
        applyStimulus(8'h40, 8'h0A, 8'h0B, 8'h0C);
        applyStimulus(8'h50, 8'h0D, 8'h0E, 8'h0F);
        applyStimulus(8'h60, 8'hAA, 8'hBB, 8'hCC);
        checkOutput("ovfLevel", 32'(fifo_level), 32'd4);
        checkOutput("ovfDrop", 32'(drop_count), 32'd1);
        captureBytes(30, 1'b0, 80);
        checkOutput("ovfGaps", 32'(gapCount), 32'd0);
        checkFrame("ovf1", 0,  8'h10, 8'h01, 8'h02, 8'h03, 8'h10);
        checkFrame("ovf2", 6,  8'h20, 8'h04, 8'h05, 8'h06, 8'h27);
        checkFrame("ovf3", 12, 8'h30, 8'h07, 8'h08, 8'h09, 8'h36);
        checkFrame("ovf4", 18, 8'h40, 8'h0A, 8'h0B, 8'h0C, 8'h4D);
        checkFrame("ovf5", 24, 8'h50, 8'h0D, 8'h0E, 8'h0F, 8'h5C);
        repeat (4) @(negedge CLK);
        checkOutput("ovfIdle", 32'(tx_valid), 32'd0);
        checkOutput("ovfLevelEnd", 32'(fifo_level), 32'd0);

        // Saturation: 300 trades stalled, drop counter pins at 255.
        tx_ready = 1'b0;
        for (int i = 0; i < 300; i++) begin
            applyStimulus(8'd42, 8'd10, 8'h07, 8'h03);
        end
        checkOutput("satDrop", 32'(drop_count), 32'd255);
        checkOutput("satLevel", 32'(fifo_level), 32'd4);

        // Release the sink and reset asynchronously during the QTY byte.
        tx_ready = 1'b1;
        found    = 1'b0;
        for (int cyc = 0; cyc < 20 && !found; cyc++) begin
            if (tx_valid && tx_byte == 8'h0A) found = 1'b1;
            else @(negedge CLK);
        end
        checkOutput("qtyWait", 32'(found), 32'd1);
        #2 RESET_N = 1'b0;
        #1;
        checkOutput("asyncValid", 32'(tx_valid), 32'd0);
        checkOutput("asyncByte", 32'(tx_byte), 32'd0);
        checkOutput("asyncLast", 32'(tx_last), 32'd0);
        checkOutput("asyncLevel", 32'(fifo_level), 32'd0);
        checkOutput("asyncDrop", 32'(drop_count), 32'd0);
        @(negedge CLK);
        RESET_N   = 1'b1;
        validSeen = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge CLK);
            if (tx_valid) validSeen++;
        end
        checkOutput("postResetIdle", 32'(validSeen), 32'd0);
        checkOutput("postResetLevel", 32'(fifo_level), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
